// File: rtl/gpio_input_conditioner_if.sv
// GPIO bank pad-side bundle: raw pad levels and output enables in,
// conditioned level plus edge pulses out.
interface gpio_input_conditioner_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pins_raw;
  logic [WIDTH-1:0] pins_writeEnable;
  logic [WIDTH-1:0] pins_read;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (output pins_raw, pins_writeEnable,
                  input  pins_read, rise, fall, changed);
  modport slave  (input  pins_raw, pins_writeEnable,
                  output pins_read, rise, fall, changed);
endinterface

// File: rtl/gpio_input_conditioner.sv
// Per-pin synchroniser + saturating debounce counter with registered rise/fall
// pulses; pins driven by the SoC bypass the debounce so read-back tracks the drive.
module gpio_ic_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CW          = 5,
  parameter int   CNT_MAX     = 15,
  parameter logic RST_V       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic we,
  output logic read,
  output logic rise,
  output logic fall,
  output logic edge_d
);
  localparam logic [CW-1:0] CMAX = CW'(CNT_MAX);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d    = '0;
    stable_d = stable_q;
    if (we) begin
      stable_d = sync_out;
    end else if (sync_out != stable_q) begin
      // accept on the Nth consecutive mismatch; counter never passes CMAX
      if (cnt_q == CMAX) stable_d = sync_out;
      else               cnt_d    = cnt_q + 1'b1;
    end
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RST_V}};
      cnt_q    <= '0;
      stable_q <= RST_V;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign read   = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign edge_d = rise_d | fall_d;
endmodule

module gpio_input_conditioner #(
  parameter int               WIDTH           = 32,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic                     io_sys_clock,
  input  logic                     io_sys_reset,
  gpio_input_conditioner_if.slave  io
);
  // zero debounce behaves as a single-cycle acceptance
  localparam int DEB_EFF = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(DEB_EFF + 1);

  logic [WIDTH-1:0] read_v, rise_v, fall_v, edge_v;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gpio_ic_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .CW          (CW),
      .CNT_MAX     (DEB_EFF - 1),
      .RST_V       (RESET_VALUE[i])
    ) u_lane (
      .clk    (io_sys_clock),
      .rst    (io_sys_reset),
      .raw    (io.pins_raw[i]),
      .we     (io.pins_writeEnable[i]),
      .read   (read_v[i]),
      .rise   (rise_v[i]),
      .fall   (fall_v[i]),
      .edge_d (edge_v[i])
    );
  end

  always_comb changed_d = |edge_v;

  always_ff @(posedge io_sys_clock or posedge io_sys_reset) begin
    if (io_sys_reset) changed_q <= 1'b0;
    else              changed_q <= changed_d;
  end

  assign io.pins_read = read_v;
  assign io.rise      = rise_v;
  assign io.fall      = fall_v;
  assign io.changed   = changed_q;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: three instances (debounce 4, debounce 0,
// reset value all-ones) checked every cycle against a sample-window model.
module tb_gpio_input_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = '0;
  logic [3:0] we  = '0;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  gpio_input_conditioner_if #(.WIDTH(4)) ifa ();
  gpio_input_conditioner_if #(.WIDTH(4)) ifb ();
  gpio_input_conditioner_if #(.WIDTH(4)) ifc ();
  assign ifa.pins_raw = raw;  assign ifa.pins_writeEnable = we;
  assign ifb.pins_raw = raw;  assign ifb.pins_writeEnable = we;
  assign ifc.pins_raw = raw;  assign ifc.pins_writeEnable = we;

  gpio_input_conditioner #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'h0))
    dut_a (.io_sys_clock(clk), .io_sys_reset(rst), .io(ifa));
  gpio_input_conditioner #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .RESET_VALUE(4'h0))
    dut_b (.io_sys_clock(clk), .io_sys_reset(rst), .io(ifb));
  gpio_input_conditioner #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'hF))
    dut_c (.io_sys_clock(clk), .io_sys_reset(rst), .io(ifc));

  logic [3:0] d_read [3];
  logic [3:0] d_rise [3];
  logic [3:0] d_fall [3];
  logic       d_chg  [3];
  assign d_read[0] = ifa.pins_read; assign d_rise[0] = ifa.rise; assign d_fall[0] = ifa.fall; assign d_chg[0] = ifa.changed;
  assign d_read[1] = ifb.pins_read; assign d_rise[1] = ifb.rise; assign d_fall[1] = ifb.fall; assign d_chg[1] = ifb.changed;
  assign d_read[2] = ifc.pins_read; assign d_rise[2] = ifc.rise; assign d_fall[2] = ifc.fall; assign d_chg[2] = ifc.changed;

  // model: a bit is accepted once its last D synchronised samples (since the
  // last reset / bypass cycle) all differ from the accepted level
  int         md  [3] = '{4, 1, 4};
  logic [3:0] mrv [3] = '{4'h0, 4'h0, 4'hF};
  logic [3:0] m_sq [3][2];
  logic [3:0] m_st [3];
  logic [3:0] m_rise [3];
  logic [3:0] m_fall [3];
  logic [31:0] m_h [3][4];
  int          m_n [3][4];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_sq[k][0] = mrv[k]; m_sq[k][1] = mrv[k]; m_st[k] = mrv[k];
        m_rise[k] = '0; m_fall[k] = '0;
        for (int b = 0; b < 4; b++) begin m_h[k][b] = '0; m_n[k][b] = 0; end
      end else begin
        logic [3:0] s, nst;
        s = m_sq[k][1];
        nst = m_st[k];
        for (int b = 0; b < 4; b++) begin
          if (we[b]) begin
            nst[b] = s[b];
            m_n[k][b] = 0;
          end else begin
            m_h[k][b] = {m_h[k][b][30:0], s[b]};
            if (m_n[k][b] < 32) m_n[k][b]++;
            if (m_n[k][b] >= md[k]) begin
              logic all_diff;
              all_diff = 1'b1;
              for (int j = 0; j < md[k]; j++)
                if (m_h[k][b][j] == m_st[k][b]) all_diff = 1'b0;
              if (all_diff) nst[b] = s[b];
            end
          end
        end
        m_rise[k] = nst & ~m_st[k];
        m_fall[k] = ~nst & m_st[k];
        m_st[k] = nst;
        m_sq[k][1] = m_sq[k][0];
        m_sq[k][0] = raw;
      end
    end
  endtask

  // inputs change at negedge+2, so at each negedge they still hold the values
  // the preceding posedge sampled
  initial begin
    forever begin
      @(negedge clk);
      model_step();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("read[%0d]", k), d_read[k], m_st[k]);
        chk($sformatf("rise[%0d]", k), d_rise[k], m_rise[k]);
        chk($sformatf("fall[%0d]", k), d_fall[k], m_fall[k]);
        chk($sformatf("changed[%0d]", k), {3'b0, d_chg[k]}, {3'b0, |(m_rise[k] | m_fall[k])});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  logic [3:0] tbl_raw [9] = '{4'hA, 4'h5, 4'h5, 4'hF, 4'h0, 4'h0, 4'h9, 4'h6, 4'h9};
  logic [3:0] tbl_we  [9] = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
  int         tbl_len [9] = '{6, 2, 6, 3, 1, 7, 3, 1, 8};

  initial begin
    tick(2);
    chk("lit_reset_a", d_read[0], 4'h0);
    chk("lit_reset_c", d_read[2], 4'hF);
    rst = 1'b0;
    // reset value all-ones, raw low at release
    tick(5);  chk("lit_c_hold", d_read[2], 4'hF);
    tick(1);  chk("lit_c_fall", d_fall[2], 4'hF);
              chk("lit_c_chg", {3'b0, d_chg[2]}, 4'h1);
              chk("lit_model_c", m_st[2], 4'h0);
    tick(1);  chk("lit_c_fall_end", d_fall[2], 4'h0);
    // single rising step; debounce 0 acts as 1
    raw = 4'h1;
    tick(3);  chk("lit_b_read", d_read[1], 4'h1);
              chk("lit_b_rise", d_rise[1], 4'h1);
    tick(2);  chk("lit_a_e5", d_read[0], 4'h0);
    tick(1);  chk("lit_a_e6", d_read[0], 4'h1);
              chk("lit_a_rise", d_rise[0], 4'h1);
              chk("lit_a_chg", {3'b0, d_chg[0]}, 4'h1);
              chk("lit_model_a", m_st[0], 4'h1);
    tick(1);  chk("lit_a_rise_end", d_rise[0], 4'h0);
              chk("lit_a_chg_end", {3'b0, d_chg[0]}, 4'h0);
    // short pulse rejected
    raw = 4'h3; tick(3); raw = 4'h1; tick(8);
    chk("lit_glitch", d_read[0], 4'h1);
    // dip restarts the count
    raw = 4'h5; tick(3); raw = 4'h1; tick(1); raw = 4'h5;
    tick(5);  chk("lit_dip_e5", d_read[0], 4'h1);
    tick(1);  chk("lit_dip_e6", d_read[0], 4'h5);
              chk("lit_dip_rise", d_rise[0], 4'h4);
    // bypass
    we = 4'h8; raw = 4'hD;
    tick(2);  chk("lit_byp_e2", d_read[0], 4'h5);
    tick(1);  chk("lit_byp_e3", d_read[0], 4'hD);
              chk("lit_byp_rise", d_rise[0], 4'h8);
              chk("lit_byp_b", d_read[1], 4'hD);
    // reset in mid-debounce
    we = 4'h0; raw = 4'h0; tick(8);
    chk("lit_clear", d_read[0], 4'h0);
    raw = 4'hF; tick(4);
    rst = 1'b1; tick(2);
    chk("lit_rst_read", d_read[0], 4'h0);
    chk("lit_rst_rise", d_rise[0], 4'h0);
    rst = 1'b0;
    tick(5);  chk("lit_rel_e5", d_read[0], 4'h0);
    tick(1);  chk("lit_rel_e6", d_read[0], 4'hF);
              chk("lit_rel_rise", d_rise[0], 4'hF);
    tick(1);  chk("lit_rel_rise_end", d_rise[0], 4'h0);
    // mixed patterns, including enables toggling mid-count
    for (int i = 0; i < 9; i++) begin
      raw = tbl_raw[i]; we = tbl_we[i];
      tick(tbl_len[i]);
    end
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
